// File: rtl/shift_pkg.sv
// Shared opcode, width and FSM definitions for the shift_seq8 command sequencer.
package shift_pkg;

  localparam int unsigned OP_W    = 3;
  localparam int unsigned SHAMT_W = 2;
  localparam int unsigned DATA_W  = 8;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
  localparam logic [OP_W-1:0] OP_LSL  = 3'b010;
  localparam logic [OP_W-1:0] OP_LSR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ASR  = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Payload presented to the downstream shifter.
  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  data;
  } sh_cmd_t;

  function automatic logic op_active(input logic [OP_W-1:0] op);
    return op inside {OP_LOAD, OP_LSL, OP_LSR, OP_ASR};
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_NOP) || op_active(op);
  endfunction

endpackage

// File: rtl/shift_seq8_if.sv
// Command and shifter-drive bundle for shift_seq8; issue_cnt exists only with SHIFT_SEQ_STATS_EN.
interface shift_seq8_if
  import shift_pkg::*;
#(
  parameter int unsigned RPT_W = 3
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [OP_W-1:0]    cmd_op;
  logic [SHAMT_W-1:0] cmd_shamt;
  logic [DATA_W-1:0]  cmd_data;
  logic [RPT_W-1:0]   cmd_rpt;
  logic [OP_W-1:0]    sh_op;
  logic [SHAMT_W-1:0] sh_shamt;
  logic [DATA_W-1:0]  sh_d_in;
  logic               busy;
  logic               done;
  logic               err;
`ifdef SHIFT_SEQ_STATS_EN
  logic [15:0]        issue_cnt;
`endif

  modport master (
`ifdef SHIFT_SEQ_STATS_EN
    input  issue_cnt,
`endif
    output cmd_valid, cmd_op, cmd_shamt, cmd_data, cmd_rpt,
    input  cmd_ready, sh_op, sh_shamt, sh_d_in, busy, done, err
  );

  modport slave (
`ifdef SHIFT_SEQ_STATS_EN
    output issue_cnt,
`endif
    input  cmd_valid, cmd_op, cmd_shamt, cmd_data, cmd_rpt,
    output cmd_ready, sh_op, sh_shamt, sh_d_in, busy, done, err
  );

endinterface

// File: rtl/shift_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags; read data is the current head (no bypass).
module shift_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          full_q;
  logic          empty_q;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CW'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/shift_seq8.sv
// Queues shift commands and replays each to the 8-bit shifter cmd_rpt+1 cycles.
// Optional SHIFT_SEQ_STATS_EN adds a saturating count of active shifter cycles.
module shift_seq8
  import shift_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RPT_W = 3
) (
  input  logic         clk,
  input  logic         reset,
  shift_seq8_if.slave  bus
);

  localparam int unsigned CMD_W  = $bits(sh_cmd_t);
  localparam int unsigned FIFO_W = CMD_W + RPT_W;

  state_e             state_q, state_d;
  logic [RPT_W-1:0]   rem_q, rem_d;
  sh_cmd_t            sh_q, sh_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               pop_c;
  logic               fifo_full;
  logic               fifo_empty;
  sh_cmd_t            wr_cmd;
  sh_cmd_t            rd_cmd;
  logic [RPT_W-1:0]   rd_rpt;
  logic [FIFO_W-1:0]  rd_word;

  assign wr_cmd = '{op: bus.cmd_op, shamt: bus.cmd_shamt, data: bus.cmd_data};

  shift_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (bus.cmd_valid),
    .wr_data_i ({wr_cmd, bus.cmd_rpt}),
    .pop_i     (pop_c),
    .rd_data_o (rd_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign {rd_cmd, rd_rpt} = rd_word;

  // Next state: a pop always starts a fresh command, from IDLE or back-to-back after a last issue.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sh_d  = '0;
        pop_c = !fifo_empty;
      end
      ST_ISSUE: begin
        if (rem_q != '0) begin
          rem_d = rem_q - RPT_W'(1);
        end else begin
          done_d = 1'b1;
          pop_c  = !fifo_empty;
          if (fifo_empty) begin
            state_d = ST_IDLE;
            sh_d    = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop_c) begin
      state_d = ST_ISSUE;
      rem_d   = rd_rpt;
      sh_d    = rd_cmd;
      if (!op_legal(rd_cmd.op)) begin
        sh_d.op = OP_NOP;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = !fifo_full;
  assign bus.sh_op     = sh_q.op;
  assign bus.sh_shamt  = sh_q.shamt;
  assign bus.sh_d_in   = sh_q.data;
  assign bus.busy      = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

`ifdef SHIFT_SEQ_STATS_EN
  logic [15:0] issue_cnt_q;

  // Counts cycles the shifter sees a real operation; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q <= '0;
    end else if (op_active(sh_q.op) && (issue_cnt_q != 16'hFFFF)) begin
      issue_cnt_q <= issue_cnt_q + 16'd1;
    end
  end

  assign bus.issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_shift_seq8.sv
// Bench for shift_seq8: directed tables, hand sequences and random traffic against a queue-based model.
module tb_shift_seq8;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  shift_seq8_if #(.RPT_W(3)) sif ();

  shift_seq8 #(.DEPTH(DEPTH), .RPT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference: queue of commands + issues left ----------------
  typedef struct {
    logic [2:0] op;
    logic [1:0] shamt;
    logic [7:0] data;
    logic [2:0] rpt;
  } cmd_t;

  cmd_t       mq[$];
  cmd_t       cur;
  cmd_t       nc;
  int         m_left = 0;
  bit         m_push;
  logic [2:0] m_op = '0;
  logic [1:0] m_sh = '0;
  logic [7:0] m_din = '0;
  logic       m_done = 1'b0, m_err = 1'b0, m_busy = 1'b0, m_ready = 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_left = 0;
      m_op = '0; m_sh = '0; m_din = '0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_push = sif.cmd_valid && (mq.size() < DEPTH);
      nc = '{sif.cmd_op, sif.cmd_shamt, sif.cmd_data, sif.cmd_rpt};
      m_done = (m_left == 1);
      m_err  = 1'b0;
      if (m_left > 1) begin
        m_left--;
      end else if (mq.size() > 0) begin
        cur    = mq.pop_front();
        m_left = int'(cur.rpt) + 1;
        m_err  = (cur.op > 3'd4);
        m_op   = m_err ? 3'd0 : cur.op;
        m_sh   = cur.shamt;
        m_din  = cur.data;
      end else begin
        m_left = 0;
        m_op = '0; m_sh = '0; m_din = '0;
      end
      if (m_push) mq.push_back(nc);
    end
    m_busy  = (m_left > 0) || (mq.size() > 0);
    m_ready = (mq.size() < DEPTH);
  end

  // ---------------- shifter model fed by sampled DUT outputs ----------------
  logic [2:0] s_op = '0;
  logic [1:0] s_sh = '0;
  logic [7:0] s_din = '0;
  logic [7:0] d_out = '0;

  always @(posedge clk) begin
    if (reset) d_out <= '0;
    else begin
      case (s_op)
        3'd1:    d_out <= s_din;
        3'd2:    d_out <= d_out << s_sh;
        3'd3:    d_out <= d_out >> s_sh;
        3'd4:    d_out <= 8'($signed(d_out) >>> s_sh);
        default: d_out <= d_out;
      endcase
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    s_op  = sif.sh_op;
    s_sh  = sif.sh_shamt;
    s_din = sif.sh_d_in;
    if (chk_en)
      chk("cycle", 32'({sif.sh_op, sif.sh_shamt, sif.sh_d_in, sif.done, sif.err, sif.busy, sif.cmd_ready}),
                   32'({m_op, m_sh, m_din, m_done, m_err, m_busy, m_ready}));
  end

  // ---------------- stimulus helpers ----------------
  int  accepted;
  bit  saw_full;

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] sh,
                       input logic [7:0] d, input logic [2:0] rpt);
    sif.cmd_valid = v; sif.cmd_op = op; sif.cmd_shamt = sh; sif.cmd_data = d; sif.cmd_rpt = rpt;
  endtask

  // Offers one command (call at a negedge); returns at the negedge after it is accepted.
  task automatic push(input logic [2:0] op, input logic [1:0] sh, input logic [7:0] d, input logic [2:0] rpt);
    int b = 0;
    drive(1'b1, op, sh, d, rpt);
    while (!sif.cmd_ready && b < 50) begin
      saw_full = 1'b1;
      @(negedge clk);
      b++;
    end
    if (b >= 50) chk("push_timeout", 32'(b), 32'(0));
    else begin
      @(posedge clk);
      accepted++;
      @(negedge clk);
    end
    sif.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while ((m_left > 0 || mq.size() > 0) && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk("drain_done", 32'(b < 300), 32'(1));
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [1:0] sh;
    logic [7:0] d;
    logic [2:0] rpt;
    logic [2:0] e_op;
    logic       e_done;
    logic       e_err;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];
  bit   done_seen;

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 2'd0, 8'd0, 3'd0);

    // 1: reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_sh_op",    32'(sif.sh_op), 32'(0));
    chk("rst_sh_shamt", 32'(sif.sh_shamt), 32'(0));
    chk("rst_sh_d_in",  32'(sif.sh_d_in), 32'(0));
    chk("rst_ready",    32'(sif.cmd_ready), 32'(1));
    chk("rst_busy",     32'(sif.busy), 32'(0));
    chk("rst_done",     32'(sif.done), 32'(0));
    chk("rst_err",      32'(sif.err), 32'(0));
    chk_en = 1'b1;
    reset = 1'b0;

    // 2: LOAD then LSL x3 ; 4: illegal opcode replayed as NOP
    tbl.push_back('{1'b1, 3'd1, 2'd0, 8'hB5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 3'd2, 2'd1, 8'hB5, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 2'd0, 8'h00, 3'd0, 3'd2, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 2'd0, 8'h00, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 2'd0, 8'h00, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 2'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 2'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 3'd6, 2'd0, 8'h3C, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 2'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 2'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 3'd0, 2'd0, 8'h00, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 3'd0, 2'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].sh, tbl[i].d, tbl[i].rpt);
      @(negedge clk);
      chk($sformatf("tbl%0d_op", i),   32'(sif.sh_op), 32'(tbl[i].e_op));
      chk($sformatf("tbl%0d_done", i), 32'(sif.done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_err", i),  32'(sif.err), 32'(tbl[i].e_err));
      chk($sformatf("tbl%0d_busy", i), 32'(sif.busy), 32'(tbl[i].e_busy));
      if (i == 6) begin
        chk("shifter_d_out", 32'(d_out), 32'h0000_00A8);
`ifdef SHIFT_SEQ_STATS_EN
        chk("issue_cnt_4", 32'(sif.issue_cnt), 32'd4);
`endif
      end
    end

    // 3: back-pressure with valid held
    accepted = 0;
    saw_full = 1'b0;
    push(3'd4, 2'd1, 8'hB5, 3'd7);
    for (int k = 0; k < 5; k++) push(3'($urandom_range(1, 4)), 2'(k), 8'(8'h10 + k), 3'd0);
    chk("bp_accepted", 32'(accepted), 32'd6);
    chk("bp_saw_full", 32'(saw_full), 32'd1);
    drain();

    // 5: reset during the 3rd issue of a rpt-7 command with two queued
    push(3'd2, 2'd1, 8'h5A, 3'd7);
    push(3'd1, 2'd0, 8'h11, 3'd0);
    push(3'd3, 2'd2, 8'h22, 3'd0);
    @(negedge clk);
    chk("mid_issue_op", 32'(sif.sh_op), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_op",    32'(sif.sh_op), 32'd0);
    chk("mid_rst_busy",  32'(sif.busy), 32'd0);
    chk("mid_rst_ready", 32'(sif.cmd_ready), 32'd1);
    chk("mid_rst_done",  32'(sif.done), 32'd0);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (sif.done || sif.err) done_seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(done_seen), 32'd0);

    // random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom),
            8'($urandom), 3'($urandom_range(0, 7)));
      @(negedge clk);
    end
    reset = 1'b0;
    sif.cmd_valid = 1'b0;
    drain();

`ifdef SHIFT_SEQ_STATS_EN
    // saturation of the active-cycle counter
    force dut.issue_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.issue_cnt_q;
    push(3'd1, 2'd0, 8'h42, 3'd2);
    drain();
    chk("issue_cnt_sat", 32'(sif.issue_cnt), 32'h0000_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
